// File: rtl/vdp_vram_dp.sv
// Dual-port VRAM responder for the VDP: RAS/CAS random port on RD/RA plus a 256-byte
// serial access memory loaded by read-transfer cycles and streamed on SD.
module vdp_vram_dp #(
    parameter int ADDR_W   = 16,
    parameter int XFER_LEN = 256
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       RAS1,
    input  logic       CAS1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic       OE1,
    input  logic [7:0] RA,
    input  logic [7:0] RD_i,
    output logic [7:0] RD_o,
    output logic       RD_oe,
    input  logic       SC,
    input  logic       SE0,
    input  logic       SE1,
    output logic [7:0] SD_o,
    output logic [1:0] SD_oe
);
    localparam int IW = $clog2(XFER_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(XFER_LEN - 1);
    localparam logic [IW-1:0] ONE_IDX  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COPY = 1'b1} cp_state_t;

    logic [7:0] mem [0:(2**ADDR_W)-1];
    logic [7:0] sam [0:XFER_LEN-1];

    logic ras_r, ras_p_r, cas_r, cas_p_r, oe_r, oe_p_r;
    logic we0_r, we0_p_r, we1_r, we1_p_r, sc_r, sc_p_r;
    logic [7:0]        row_r, xrow_r;
    logic [ADDR_W-1:0] addr_r;
    logic              xfer_cyc_r, xfer_pend_r, col_valid_r;
    logic [IW-1:0]     ptr_r, i_r, i_s;
    cp_state_t         state_r, state_s;
    logic              copy_we_s;

    logic              ras_fall_s, ras_rise_s, cas_fall_s, sc_rise_s;
    logic              wr_en_s, xfer_go_s, rd_en_s;
    logic [ADDR_W-1:0] wr_addr_s, cp_addr_s, byp_addr_s;
    logic [7:0]        wr_byte_s, cp_byte_s, sd_byte_s;

    assign ras_fall_s = ras_p_r & ~ras_r;
    assign ras_rise_s = ~ras_p_r & ras_r;
    assign cas_fall_s = cas_p_r & ~cas_r & ~ras_r;
    assign sc_rise_s  = sc_r & ~sc_p_r;

    assign wr_en_s   = cas_fall_s & ~xfer_cyc_r & (~we0_r | ~we1_r);
    assign xfer_go_s = cas_fall_s & xfer_cyc_r & xfer_pend_r;
    // Reads wait for the delayed strobe copies so RD_o and RD_oe appear together.
    assign rd_en_s   = col_valid_r & ~xfer_cyc_r & ~ras_p_r & ~cas_p_r & ~oe_p_r
                       & we0_p_r & we1_p_r;

    assign wr_addr_s = {row_r, RA};
    assign wr_byte_s = {we1_r ? mem[wr_addr_s][7:4] : RD_i[7:4],
                        we0_r ? mem[wr_addr_s][3:0] : RD_i[3:0]};

    // Port B forwards a same-cycle write so the SAM captures the post-write byte.
    assign cp_addr_s  = {xrow_r, i_r};
    assign cp_byte_s  = (wr_en_s && (wr_addr_s == cp_addr_s)) ? wr_byte_s : mem[cp_addr_s];
    assign byp_addr_s = {xrow_r, ptr_r};
    assign sd_byte_s  = ((state_r == ST_COPY) && (ptr_r >= i_r)) ? mem[byp_addr_s] : sam[ptr_r];

    // Copy engine next-state: one SAM byte per MCLK while in COPY.
    always_comb begin
        state_s   = state_r;
        i_s       = i_r;
        copy_we_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_go_s) begin
                    state_s = ST_COPY;
                    i_s     = {IW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COPY: begin
                copy_we_s = 1'b1;
                if (xfer_go_s) begin
                    state_s = ST_COPY;
                    i_s     = {IW{1'b0}};
                end else if (i_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                end else begin
                    i_s = i_r + ONE_IDX;
                end
            end
            default: begin
                state_s = ST_IDLE;
                i_s     = {IW{1'b0}};
            end
        endcase
    end

    // Strobe history, cycle decode, pointers and registered outputs.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ras_r       <= 1'b1;
            ras_p_r     <= 1'b1;
            cas_r       <= 1'b1;
            cas_p_r     <= 1'b1;
            oe_r        <= 1'b1;
            oe_p_r      <= 1'b1;
            we0_r       <= 1'b1;
            we0_p_r     <= 1'b1;
            we1_r       <= 1'b1;
            we1_p_r     <= 1'b1;
            sc_r        <= 1'b1;
            sc_p_r      <= 1'b1;
            row_r       <= 8'h00;
            xrow_r      <= 8'h00;
            addr_r      <= {ADDR_W{1'b0}};
            xfer_cyc_r  <= 1'b0;
            xfer_pend_r <= 1'b0;
            col_valid_r <= 1'b0;
            ptr_r       <= {IW{1'b0}};
            state_r     <= ST_IDLE;
            i_r         <= {IW{1'b0}};
            RD_o        <= 8'h00;
            RD_oe       <= 1'b0;
            SD_o        <= 8'h00;
            SD_oe       <= 2'b00;
        end else begin
            ras_r   <= RAS1;
            ras_p_r <= ras_r;
            cas_r   <= CAS1;
            cas_p_r <= cas_r;
            oe_r    <= OE1;
            oe_p_r  <= oe_r;
            we0_r   <= WE0;
            we0_p_r <= we0_r;
            we1_r   <= WE1;
            we1_p_r <= we1_r;
            sc_r    <= SC;
            sc_p_r  <= sc_r;
            state_r <= state_s;
            i_r     <= i_s;
            SD_oe   <= {~SE1, ~SE0};
            RD_oe   <= rd_en_s;

            if (ras_fall_s) begin
                row_r       <= RA;
                xfer_cyc_r  <= ~oe_r;
                xfer_pend_r <= ~oe_r;
                col_valid_r <= 1'b0;
            end else if (ras_rise_s) begin
                xfer_cyc_r  <= 1'b0;
                col_valid_r <= 1'b0;
            end else if (cas_fall_s && xfer_cyc_r) begin
                xfer_pend_r <= 1'b0;
                if (xfer_pend_r) begin
                    xrow_r <= row_r;
                end
            end else if (cas_fall_s) begin
                addr_r      <= {row_r, RA};
                col_valid_r <= 1'b1;
            end

            if (xfer_go_s) begin
                ptr_r <= RA;
            end else if (sc_rise_s) begin
                ptr_r <= ptr_r + ONE_IDX;
            end

            if (sc_rise_s) begin
                SD_o <= sd_byte_s;
            end
            if (rd_en_s) begin
                RD_o <= mem[addr_r];
            end
        end
    end

    // Array and SAM storage survive RESET; only new writes are suppressed.
    always_ff @(posedge MCLK) begin
        if (wr_en_s && !RESET) begin
            mem[wr_addr_s] <= wr_byte_s;
        end
    end

    // SAM fill from array port B.
    always_ff @(posedge MCLK) begin
        if (copy_we_s && !RESET) begin
            sam[i_r] <= cp_byte_s;
        end
    end
endmodule

// File: tb/tb_vdp_vram_dp.sv
// Scoreboard bench for vdp_vram_dp: stimulus pushes expected RD/SD bytes computed from a
// byte-array model of the VRAM and SAM; a monitor pops them as the DUT presents data.
module tb_vdp_vram_dp;
    logic       MCLK = 1'b0;
    logic       RESET, RAS1, CAS1, WE0, WE1, OE1, SC, SE0, SE1;
    logic [7:0] RA, RD_i, RD_o, SD_o;
    logic       RD_oe;
    logic [1:0] SD_oe;

    vdp_vram_dp #(.ADDR_W(16), .XFER_LEN(256)) dut (
        .MCLK(MCLK), .RESET(RESET), .RAS1(RAS1), .CAS1(CAS1), .WE0(WE0), .WE1(WE1),
        .OE1(OE1), .RA(RA), .RD_i(RD_i), .RD_o(RD_o), .RD_oe(RD_oe), .SC(SC),
        .SE0(SE0), .SE1(SE1), .SD_o(SD_o), .SD_oe(SD_oe)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        bit         chk;
        logic [7:0] val;
    } sd_exp_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rd_q [$];
    sd_exp_t    sd_q [$];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] ref_sam [0:255];
    logic [7:0] ref_ptr = 8'h00;
    logic [7:0] cur_row = 8'h00;
    logic [15:0] pool [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic ras_fall(input logic [7:0] row, input logic oe);
        RA = row; OE1 = oe; RAS1 = 1'b0; cur_row = row;
        cyc(2);
    endtask

    task automatic ras_rise();
        RAS1 = 1'b1; OE1 = 1'b1;
        cyc(3);
    endtask

    task automatic cas_write(input logic [7:0] col, input logic [7:0] data, input logic [1:0] we_n);
        logic [15:0] a;
        a = {cur_row, col};
        if (!we_n[0]) ref_mem[a][3:0] = data[3:0];
        if (!we_n[1]) ref_mem[a][7:4] = data[7:4];
        RA = col; RD_i = data; WE0 = we_n[0]; WE1 = we_n[1]; CAS1 = 1'b0;
        cyc(3);
        CAS1 = 1'b1; WE0 = 1'b1; WE1 = 1'b1;
        cyc(2);
    endtask

    task automatic cas_read(input logic [7:0] col);
        logic [7:0] e;
        e = ref_mem[{cur_row, col}];
        rd_q.push_back(e);
        RA = col; OE1 = 1'b0; CAS1 = 1'b0;
        cyc(4);
        OE1 = 1'b1;
        cyc(3);
        check("rd_oe_drop", {31'd0, RD_oe}, 32'd0);
        check("rd_hold", {24'd0, RD_o}, {24'd0, e});
        CAS1 = 1'b1;
        cyc(2);
    endtask

    task automatic write_byte(input logic [15:0] a, input logic [7:0] d, input logic [1:0] we_n);
        ras_fall(a[15:8], 1'b1);
        cas_write(a[7:0], d, we_n);
        ras_rise();
    endtask

    task automatic read_byte(input logic [15:0] a);
        ras_fall(a[15:8], 1'b1);
        cas_read(a[7:0]);
        ras_rise();
    endtask

    task automatic xfer(input logic [7:0] row, input logic [7:0] col);
        ras_fall(row, 1'b0);
        RA = col; CAS1 = 1'b0;
        cyc(3);
        CAS1 = 1'b1;
        cyc(1);
        ras_rise();
        ref_ptr = col;
    endtask

    task automatic sc_pulse(input bit chk, input logic [7:0] val);
        sd_exp_t e;
        e.chk = chk; e.val = val;
        sd_q.push_back(e);
        SC = 1'b1;
        cyc(2);
        SC = 1'b0;
        cyc(2);
        ref_ptr = ref_ptr + 8'd1;
    endtask

    task automatic snap_row(input logic [7:0] row);
        for (int k = 0; k < 256; k++) ref_sam[k] = ref_mem[{row, 8'(k)}];
    endtask

    // Monitor: compares each presented RD read and each SC-triggered SD byte.
    bit         mon_sc_last = 1'b0;
    bit         mon_sd_pend = 1'b0;
    bit         mon_oe_last = 1'b0;
    sd_exp_t    mon_e;
    logic [7:0] mon_rd;
    initial begin
        forever begin
            @(posedge MCLK);
            #1;
            if (mon_sd_pend) begin
                mon_sd_pend = 1'b0;
                if (sd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sd_unexpected: actual %0h required none", SD_o);
                end else begin
                    mon_e = sd_q.pop_front();
                    if (mon_e.chk) check("sd_byte", {24'd0, SD_o}, {24'd0, mon_e.val});
                end
            end
            if (SC && !mon_sc_last) mon_sd_pend = 1'b1;
            mon_sc_last = SC;
            if (RD_oe && !mon_oe_last) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: actual %0h required none", RD_o);
                end else begin
                    mon_rd = rd_q.pop_front();
                    check("rd_byte", {24'd0, RD_o}, {24'd0, mon_rd});
                end
            end
            mon_oe_last = RD_oe;
        end
    end

    initial begin
        logic [1:0] wen;
        int         j;
        RESET = 1'b1; RAS1 = 1'b1; CAS1 = 1'b1; WE0 = 1'b1; WE1 = 1'b1; OE1 = 1'b1;
        SC = 1'b0; SE0 = 1'b1; SE1 = 1'b1; RA = 8'h00; RD_i = 8'h00;
        cyc(3);
        check("rst_rd_o", {24'd0, RD_o}, 32'd0);
        check("rst_rd_oe", {31'd0, RD_oe}, 32'd0);
        check("rst_sd_o", {24'd0, SD_o}, 32'd0);
        check("rst_sd_oe", {30'd0, SD_oe}, 32'd0);
        RESET = 1'b0;
        cyc(2);

        // Write/read-back, nibble write, CAS-before-RAS ignored.
        write_byte(16'h1234, 8'hA5, 2'b00);
        read_byte(16'h1234);
        write_byte(16'h1234, 8'h3C, 2'b01);
        RA = 8'h34; RD_i = 8'hFF; WE0 = 1'b0; WE1 = 1'b0; CAS1 = 1'b0;
        cyc(3);
        CAS1 = 1'b1; WE0 = 1'b1; WE1 = 1'b1;
        cyc(2);
        read_byte(16'h1234);
        check("nibble_model", {24'd0, ref_mem[16'h1234]}, 32'h35);

        // Page mode writes then page mode reads.
        ras_fall(8'h40, 1'b1);
        for (int c = 0; c < 4; c++) cas_write(8'(c), 8'h10 + 8'(c), 2'b00);
        for (int c = 0; c < 4; c++) cas_read(8'(c));
        ras_rise();

        // Randomized writes with random nibble enables and reads over a small pool.
        for (int p = 0; p < 8; p++) begin
            pool[p] = {8'h20 + 8'(p), 8'($urandom)};
            write_byte(pool[p], 8'($urandom), 2'b00);
        end
        for (int n = 0; n < 40; n++) begin
            j = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: wen = 2'b00;
                    1: wen = 2'b10;
                    default: wen = 2'b01;
                endcase
                write_byte(pool[j], 8'($urandom), wen);
            end else begin
                read_byte(pool[j]);
            end
        end

        // Fill row 7 with its column index, transfer from column 0xFE and stream.
        ras_fall(8'h07, 1'b1);
        for (int k = 0; k < 256; k++) cas_write(8'(k), 8'(k), 2'b00);
        ras_rise();
        xfer(8'h07, 8'hFE);
        cyc(260);
        snap_row(8'h07);
        SE0 = 1'b0;
        cyc(2);
        check("sd_oe_lo", {30'd0, SD_oe}, 32'h1);
        SE1 = 1'b0;
        cyc(2);
        check("sd_oe_both", {30'd0, SD_oe}, 32'h3);
        for (int k = 0; k < 4; k++) sc_pulse(1'b1, ref_sam[ref_ptr]);

        // Completed SAM is a snapshot: later array write is invisible.
        write_byte(16'h0705, 8'h99, 2'b00);
        for (int k = 0; k < 4; k++) sc_pulse(1'b1, ref_sam[ref_ptr]);

        // During COPY with the pointer ahead of the copy index, SD sees the live array.
        write_byte(16'h0780, 8'h5A, 2'b00);
        xfer(8'h07, 8'h80);
        sc_pulse(1'b1, ref_mem[{8'h07, ref_ptr}]);
        cyc(300);
        snap_row(8'h07);

        // Reset ten cycles into a copy of row 9.
        write_byte(16'h0900, 8'h77, 2'b00);
        write_byte(16'h0905, 8'h11, 2'b00);
        write_byte(16'h09F0, 8'h44, 2'b00);
        xfer(8'h09, 8'h40);
        cyc(4);
        RESET = 1'b1;
        cyc(2);
        check("mid_rst_rd_o", {24'd0, RD_o}, 32'd0);
        check("mid_rst_rd_oe", {31'd0, RD_oe}, 32'd0);
        check("mid_rst_sd_o", {24'd0, SD_o}, 32'd0);
        check("mid_rst_sd_oe", {30'd0, SD_oe}, 32'd0);
        RESET = 1'b0;
        cyc(2);
        ref_ptr = 8'h00;
        ref_sam[0] = ref_mem[16'h0900];
        ref_sam[5] = ref_mem[16'h0905];
        for (int p = 0; p <= 8'hF0; p++) sc_pulse((p == 0) || (p == 5) || (p == 8'hF0), ref_sam[p]);
        read_byte(16'h1234);

        cyc(6);
        check("rd_queue_empty", rd_q.size(), 32'd0);
        check("sd_queue_empty", sd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
